// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the UART transmit path: the character write strobe, the
// FIFO flush, and the status flags fed back to the LSR/THRE logic.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       pi_tx_data;
    logic             pi_flag;
    logic             fifo_clr;
    logic             po_flag;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_idle;
    logic             tx_overflow;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output pi_tx_data, pi_flag, fifo_clr,
        input  po_flag, tx_full, tx_empty, tx_idle, tx_overflow, fifo_count
    );

    modport slave (
        input  pi_tx_data, pi_flag, fifo_clr,
        output po_flag, tx_full, tx_empty, tx_idle, tx_overflow, fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmit path: a power-of-two character FIFO in front of a serialiser
// with 5-8 data bits, optional even/odd/stick parity, 1/1.5/2 stop bits and
// break. Frame configuration is captured when a character leaves the FIFO,
// so register writes made mid-frame only affect the following character.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_fifo_if.slave        bus,
    input  logic [1:0]           word_length,
    input  logic [DIV_WIDTH-1:0] baud_rate_cnt,
    input  logic                 parity_en,
    input  logic                 even_parity,
    input  logic                 stick_parity,
    input  logic                 stop_bits,
    input  logic                 set_break,
    output logic                 tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DIV_WIDTH:0] ONE = {{DIV_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 overflow;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    state_t               state;
    state_t               state_next;
    logic [DIV_WIDTH:0]   timer;
    logic [DIV_WIDTH:0]   timer_next;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_next;
    logic [7:0]           shift;
    logic [7:0]           shift_next;
    logic                 tx_q;
    logic                 tx_next;

    logic [1:0]           wl_q;
    logic                 pe_q;
    logic                 sb_q;
    logic                 par_q;
    logic [DIV_WIDTH-1:0] div_q;

    logic [DIV_WIDTH-1:0] div_eff;
    logic [7:0]           head;
    logic [7:0]           head_masked;
    logic                 head_par;
    logic [DIV_WIDTH:0]   start_period;
    logic [DIV_WIDTH:0]   bit_period;
    logic [DIV_WIDTH:0]   stop_period;
    logic [2:0]           last_bit;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = bus.pi_flag && !full && !bus.fifo_clr;

    // A zero divisor would stall the bit timer, so it runs at one clock per bit.
    assign div_eff = (baud_rate_cnt == '0) ? {{(DIV_WIDTH-1){1'b0}}, 1'b1} : baud_rate_cnt;

    // Parity is worked out from the FIFO head as it is popped, using only the
    // bits that will actually be sent.
    assign head        = mem[rd_ptr];
    assign head_masked = head & (8'hFF >> (2'd3 - word_length));
    assign head_par    = stick_parity ? ~even_parity
                       : (even_parity ? ^head_masked : ~^head_masked);

    // Timer reload values are one less than the period since the timer counts to zero.
    assign start_period = {1'b0, div_eff} - ONE;
    assign bit_period   = {1'b0, div_q} - ONE;
    assign stop_period  = !sb_q ? bit_period
                        : (wl_q == 2'd0) ? ({1'b0, div_q} + {2'b00, div_q[DIV_WIDTH-1:1]} - ONE)
                        : ({div_q, 1'b0} - ONE);
    assign last_bit     = 3'd4 + {1'b0, wl_q};

    assign tx              = tx_q & ~set_break;
    assign bus.po_flag     = (state == STOP) && (timer == '0);
    assign bus.tx_full     = full;
    assign bus.tx_empty    = empty;
    assign bus.tx_idle     = empty && (state == IDLE);
    assign bus.tx_overflow = overflow;
    assign bus.fifo_count  = count;

    // FIFO pointers, occupancy and the sticky overflow flag; a flush overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (bus.fifo_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (bus.pi_flag && full) overflow <= 1'b1;
        end
    end

    // FIFO storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.pi_tx_data;
    end

    // Capture the character's frame settings at the moment it is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wl_q  <= 2'd0;
            pe_q  <= 1'b0;
            sb_q  <= 1'b0;
            par_q <= 1'b0;
            div_q <= '0;
        end else if (pop) begin
            wl_q  <= word_length;
            pe_q  <= parity_en;
            sb_q  <= stop_bits;
            par_q <= head_par;
            div_q <= div_eff;
        end
    end

    // Serialiser state, bit timer, data shifter and the registered line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            tx_q    <= tx_next;
        end
    end

    // Frame sequencing; the line level is derived from the next state so tx changes with the state.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        pop          = 1'b0;
        tx_next      = 1'b1;

        case (state)
            IDLE: begin
                pop = !empty && !bus.fifo_clr;
            end
            START: begin
                if (timer == '0) begin
                    state_next   = DATA;
                    timer_next   = bit_period;
                    bit_cnt_next = 3'd0;
                end else begin
                    timer_next = timer - ONE;
                end
            end
            DATA: begin
                if (timer == '0) begin
                    timer_next = bit_period;
                    if (bit_cnt == last_bit) begin
                        if (pe_q) begin
                            state_next = PARITY;
                        end else begin
                            state_next = STOP;
                            timer_next = stop_period;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                    end
                end else begin
                    timer_next = timer - ONE;
                end
            end
            PARITY: begin
                if (timer == '0) begin
                    state_next = STOP;
                    timer_next = stop_period;
                end else begin
                    timer_next = timer - ONE;
                end
            end
            STOP: begin
                if (timer == '0) begin
                    if (!empty && !bus.fifo_clr) pop = 1'b1;
                    else                         state_next = IDLE;
                end else begin
                    timer_next = timer - ONE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop) begin
            state_next   = START;
            timer_next   = start_period;
            bit_cnt_next = 3'd0;
            shift_next   = head;
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_q;
            default: tx_next = 1'b1;
        endcase
    end
endmodule
